// File: rtl/xif_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_resp_pkg
// Description : Shared types, encodings and helpers for the XIF memory
//               responder (FSM states, access sizes, exception codes, FIFO
//               entry layout, lane steering functions).
// Revision    : 1.0 - initial release
// ============================================================================
package xif_mem_resp_pkg;

  // Bus-request FSM: IDLE (nothing on data_*) / REQ (request held until grant)
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_REQ  = 1'b1;

  // x_mem_req_size encodings
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  // Exception codes returned on the x_mem response
  localparam logic [5:0] EXC_LOAD  = 6'd4;
  localparam logic [5:0] EXC_STORE = 6'd6;
  localparam logic [5:0] EXC_SPEC  = 6'd0;

  // Per-transaction bookkeeping kept between grant and rvalid. The store flag
  // rides along so store results can report zero read data.
  typedef struct packed {
    logic       we;
    logic [1:0] offset;
    logic [1:0] size;
  } fifo_meta_t;

  // A request is refused when its size is reserved, it is misaligned for its
  // size, or it is still speculative.
  function automatic logic req_illegal(input logic [1:0] size,
                                       input logic [1:0] off,
                                       input logic       spec);
    logic misaligned;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      SIZE_WORD: misaligned = (off != 2'b00);
      default:   misaligned = 1'b1;
    endcase
    return misaligned | spec;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << off;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Move the addressed lanes of a bus word down to bit 0 and clear the rest
  function automatic logic [31:0] align_rdata(input logic [31:0] rdata,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      SIZE_BYTE: res = {24'h0, sh[7:0]};
      SIZE_HALF: res = {16'h0, sh[15:0]};
      default:   res = sh;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xif_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_responder_if
// Description : Bundles the x_mem request/response, x_mem_result and OBI
//               data-bus signals seen by the memory responder. The slave
//               modport is the responder's view, master the environment's.
// Revision    : 1.0 - initial release
// ============================================================================
interface xif_mem_responder_if #(
  parameter int unsigned ID_WIDTH = 4
);
  // x_mem request / immediate response
  logic                x_mem_valid;
  logic                x_mem_ready;
  logic [ID_WIDTH-1:0] x_mem_req_id;
  logic [31:0]         x_mem_req_addr;
  logic                x_mem_req_we;
  logic [1:0]          x_mem_req_size;
  logic [31:0]         x_mem_req_wdata;
  logic                x_mem_req_spec;
  logic                x_mem_resp_exc;
  logic [5:0]          x_mem_resp_exccode;
  // x_mem_result
  logic                x_mem_result_valid;
  logic [ID_WIDTH-1:0] x_mem_result_id;
  logic [31:0]         x_mem_result_rdata;
  logic                x_mem_result_err;
  // OBI data bus
  logic                data_req;
  logic                data_gnt;
  logic [31:0]         data_addr;
  logic                data_we;
  logic [3:0]          data_be;
  logic [31:0]         data_wdata;
  logic                data_rvalid;
  logic [31:0]         data_rdata;
  logic                data_err;

  modport slave (
    input  x_mem_valid, x_mem_req_id, x_mem_req_addr, x_mem_req_we,
           x_mem_req_size, x_mem_req_wdata, x_mem_req_spec,
    output x_mem_ready, x_mem_resp_exc, x_mem_resp_exccode,
    output x_mem_result_valid, x_mem_result_id, x_mem_result_rdata,
           x_mem_result_err,
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport master (
    output x_mem_valid, x_mem_req_id, x_mem_req_addr, x_mem_req_we,
           x_mem_req_size, x_mem_req_wdata, x_mem_req_spec,
    input  x_mem_ready, x_mem_resp_exc, x_mem_resp_exccode,
    input  x_mem_result_valid, x_mem_result_id, x_mem_result_rdata,
           x_mem_result_err,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );

endinterface
`default_nettype wire

// File: rtl/xif_mem_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_id_fifo
// Description : DEPTH-entry FIFO of transaction tags (id + lane info) for
//               requests granted on the bus and still awaiting rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_mem_id_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  // A pop frees a slot in the same cycle, so a full FIFO may still accept
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/xif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : xif_mem_responder
// Description : Core-side CORE-V-XIF x_mem / x_mem_result responder. Accepts
//               load/store requests, rejects illegal ones with an immediate
//               exception, issues legal ones on the OBI data bus and returns
//               results in order as rvalid arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_mem_responder
  import xif_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_busy_i,
  xif_mem_responder_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    fifo_meta_t          meta;
  } entry_t;

  state_t         state_q;
  state_t         state_d;
  entry_t         tag_q;
  logic [31:0]    data_addr_q;
  logic [3:0]     data_be_q;
  logic [31:0]    data_wdata_q;

  entry_t         w_head;
  entry_t         w_new_tag;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0] w_count_next;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_ready;
  logic           w_hs;
  logic           w_illegal;
  logic           w_accept;
  logic [1:0]     w_off;

  assign w_off     = bus.x_mem_req_addr[1:0];
  assign w_illegal = req_illegal(bus.x_mem_req_size, w_off, bus.x_mem_req_spec);

  // Grant of the held request enqueues its tag; rvalid retires the oldest
  assign w_push = (state_q == ST_REQ) & bus.data_gnt;
  assign w_pop  = bus.data_rvalid & ~w_fifo_empty;
  assign w_count_next = {1'b0, w_count} + {{CNT_W{1'b0}}, w_push}
                      - {{CNT_W{1'b0}}, w_pop};

  // New request only when the bus slot is free (or freeing this cycle) and
  // the in-flight budget still has room after this cycle's push/pop
  assign w_ready  = ~rst_i & ~lsu_busy_i
                  & ((state_q == ST_IDLE) | w_push)
                  & (w_count_next < (CNT_W + 1)'(DEPTH));
  assign w_hs     = bus.x_mem_valid & w_ready;
  assign w_accept = w_hs & ~w_illegal;

  assign bus.x_mem_ready        = w_ready;
  assign bus.x_mem_resp_exc     = w_hs & w_illegal;
  assign bus.x_mem_resp_exccode = ~(w_hs & w_illegal) ? 6'd0
                                : bus.x_mem_req_spec  ? EXC_SPEC
                                : bus.x_mem_req_we    ? EXC_STORE
                                :                       EXC_LOAD;

  assign w_new_tag.id          = bus.x_mem_req_id;
  assign w_new_tag.meta.we     = bus.x_mem_req_we;
  assign w_new_tag.meta.offset = w_off;
  assign w_new_tag.meta.size   = bus.x_mem_req_size;

  // Next FSM state: a fresh accept wins over returning to idle on grant
  always_comb begin
    state_d = state_q;
    if (w_accept)    state_d = ST_REQ;
    else if (w_push) state_d = ST_IDLE;
  end

  // Hold the accepted request on the bus until it is granted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      data_addr_q  <= '0;
      data_be_q    <= '0;
      data_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        tag_q        <= w_new_tag;
        data_addr_q  <= {bus.x_mem_req_addr[31:2], 2'b00};
        data_be_q    <= byte_enable(bus.x_mem_req_size, w_off);
        data_wdata_q <= bus.x_mem_req_wdata << {w_off, 3'b000};
      end
    end
  end

  assign bus.data_req   = (state_q == ST_REQ);
  assign bus.data_addr  = data_addr_q;
  assign bus.data_we    = tag_q.meta.we;
  assign bus.data_be    = data_be_q;
  assign bus.data_wdata = data_wdata_q;

  xif_mem_id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push & (~w_fifo_full | w_pop)),
    .data_i  (tag_q),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Results are combinational from rvalid; stores report zero data
  assign bus.x_mem_result_valid = w_pop;
  assign bus.x_mem_result_id    = w_head.id;
  assign bus.x_mem_result_rdata = (w_pop & ~w_head.meta.we)
                                ? align_rdata(bus.data_rdata, w_head.meta.offset,
                                              w_head.meta.size)
                                : 32'h0;
  assign bus.x_mem_result_err   = w_pop & bus.data_err;

endmodule
`default_nettype wire

// File: tb/tb_xif_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_mem_responder
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic compared every cycle against a transaction-level
//               model (pending request + in-flight queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_mem_responder;

  localparam int DEPTH = 2;
  localparam int IDW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lsu_busy = 1'b0;
  always #5 clk = ~clk;

  xif_mem_responder_if #(.ID_WIDTH(IDW)) bus ();

  xif_mem_responder #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .lsu_busy_i (lsu_busy),
    .bus        (bus.slave)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic           we;
    logic [1:0]     size;
    logic [31:0]    wdata;
    logic           spec;
  } req_t;

  req_t cur;
  req_t pend;
  bit   pend_v;
  req_t inflight[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_pop, m_push, m_hs, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.x_mem_valid = 0; bus.x_mem_req_id = '0; bus.x_mem_req_addr = '0;
    bus.x_mem_req_we = 0; bus.x_mem_req_size = '0; bus.x_mem_req_wdata = '0;
    bus.x_mem_req_spec = 0; bus.data_gnt = 0; bus.data_rvalid = 0;
    bus.data_rdata = '0; bus.data_err = 0; lsu_busy = 0;
  endtask

  task automatic drive_req(input req_t r);
    cur = r;
    bus.x_mem_valid = 1; bus.x_mem_req_id = r.id; bus.x_mem_req_addr = r.addr;
    bus.x_mem_req_we = r.we; bus.x_mem_req_size = r.size;
    bus.x_mem_req_wdata = r.wdata; bus.x_mem_req_spec = r.spec;
  endtask

  function automatic req_t mk(input int id, input logic [31:0] addr, input bit we,
                              input int size, input logic [31:0] wdata, input bit spec);
    req_t r;
    r.id = IDW'(id); r.addr = addr; r.we = we; r.size = 2'(size);
    r.wdata = wdata; r.spec = spec;
    return r;
  endfunction

  function automatic bit is_illegal(input req_t r);
    int off = int'(r.addr[1:0]);
    if (r.spec) return 1;
    if (r.size == 3) return 1;
    if (r.size == 2 && off != 0) return 1;
    if (r.size == 1 && (off % 2) != 0) return 1;
    return 0;
  endfunction

  // Lanes covered: byte offset up to offset+bytes-1
  function automatic logic [3:0] exp_be(input req_t r);
    logic [3:0] be = '0;
    int off = int'(r.addr[1:0]);
    int nb = 1 << r.size;
    for (int b = 0; b < 4; b++) be[b] = (b >= off && b < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] exp_rdata(input req_t r, input logic [31:0] d);
    logic [31:0] v = '0;
    int off = int'(r.addr[1:0]);
    int nb = 1 << r.size;
    if (r.we) return 32'h0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = d[8*(off+b) +: 8];
    return v;
  endfunction

  // Compare every output against the model for the inputs now applied
  task automatic model_check();
    int cnt_next;
    bit rdy;
    logic [5:0] code;
    #1;
    m_pop    = bus.data_rvalid && inflight.size() > 0;
    m_push   = pend_v && bus.data_gnt;
    cnt_next = inflight.size() + int'(m_push) - int'(m_pop);
    rdy      = !lsu_busy && (!pend_v || m_push) && cnt_next < DEPTH;
    m_hs     = bus.x_mem_valid && rdy;
    m_ill    = m_hs && is_illegal(cur);
    code     = !m_ill ? 6'd0 : cur.spec ? 6'd0 : cur.we ? 6'd6 : 6'd4;
    chk("ready", bus.x_mem_ready, rdy);
    chk("exc", bus.x_mem_resp_exc, m_ill);
    chk("exccode", bus.x_mem_resp_exccode, code);
    chk("result_valid", bus.x_mem_result_valid, m_pop);
    if (m_pop) begin
      chk("result_id", bus.x_mem_result_id, inflight[0].id);
      chk("result_rdata", bus.x_mem_result_rdata, exp_rdata(inflight[0], bus.data_rdata));
      chk("result_err", bus.x_mem_result_err, bus.data_err);
    end
    chk("data_req", bus.data_req, pend_v);
    if (pend_v) begin
      chk("data_addr", bus.data_addr, {pend.addr[31:2], 2'b00});
      chk("data_we", bus.data_we, pend.we);
      chk("data_be", bus.data_be, exp_be(pend));
      chk("data_wdata", bus.data_wdata, pend.wdata << (8 * int'(pend.addr[1:0])));
    end
  endtask

  task automatic tick();
    if (m_pop) void'(inflight.pop_front());
    if (m_push) begin inflight.push_back(pend); pend_v = 0; end
    if (m_hs && !m_ill) begin pend = cur; pend_v = 1; end
    @(posedge clk); #1;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.id = IDW'($urandom); r.addr = $urandom; r.we = 1'($urandom);
    r.wdata = $urandom; r.spec = 0;
    r.size = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
    if ($urandom % 4 != 0) r.addr = r.addr & ~((32'd1 << r.size) - 1);
    if ($urandom % 16 == 0) begin
      r.spec = 1; r.size = 2'($urandom % 3); r.addr[1:0] = 2'b00;
    end
    return r;
  endfunction

  initial begin
    bit hold;
    idle_inputs();
    pend_v = 0;
    // Reset state, with a request offered to show ready is held low
    drive_req(mk(1, 32'h0, 0, 2, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.x_mem_ready, 0);
    chk("rst_data_req", bus.data_req, 0);
    chk("rst_data_addr", bus.data_addr, 0);
    chk("rst_data_be", bus.data_be, 0);
    chk("rst_data_wdata", bus.data_wdata, 0);
    chk("rst_result_valid", bus.x_mem_result_valid, 0);
    chk("rst_exc", bus.x_mem_resp_exc, 0);
    chk("rst_exccode", bus.x_mem_resp_exccode, 0);
    rst = 0;
    idle_inputs();

    // Word load at 0x100, grant N+1, rvalid N+3
    drive_req(mk(3, 32'h100, 0, 2, 0, 0)); model_check();
    chk("t1_ready", bus.x_mem_ready, 1); tick();
    idle_inputs(); bus.data_gnt = 1; model_check();
    chk("t1_req", bus.data_req, 1); chk("t1_be", bus.data_be, 4'b1111);
    chk("t1_addr", bus.data_addr, 32'h100); tick();
    idle_inputs(); model_check(); tick();
    bus.data_rvalid = 1; bus.data_rdata = 32'hDEADBEEF; model_check();
    chk("t1_rvalid", bus.x_mem_result_valid, 1); chk("t1_id", bus.x_mem_result_id, 3);
    chk("t1_rdata", bus.x_mem_result_rdata, 32'hDEADBEEF);
    chk("t1_err", bus.x_mem_result_err, 0); tick();

    // Byte store at 0x203
    idle_inputs(); drive_req(mk(5, 32'h203, 1, 0, 32'hAB, 0)); model_check(); tick();
    idle_inputs(); bus.data_gnt = 1; model_check();
    chk("t2_addr", bus.data_addr, 32'h200); chk("t2_be", bus.data_be, 4'b1000);
    chk("t2_wdata", bus.data_wdata, 32'hAB000000); chk("t2_we", bus.data_we, 1); tick();
    idle_inputs(); bus.data_rvalid = 1; bus.data_rdata = 32'h12345678; model_check();
    chk("t2_rvalid", bus.x_mem_result_valid, 1); chk("t2_rdata", bus.x_mem_result_rdata, 0); tick();

    // Misaligned half load: immediate exception, no bus access, no result
    idle_inputs(); drive_req(mk(6, 32'h101, 0, 1, 0, 0)); model_check();
    chk("t3_exc", bus.x_mem_resp_exc, 1); chk("t3_code", bus.x_mem_resp_exccode, 4); tick();
    idle_inputs(); bus.data_rvalid = 1; model_check();
    chk("t3_req", bus.data_req, 0); chk("t3_noresult", bus.x_mem_result_valid, 0); tick();

    // In-flight limit: third request waits for the first rvalid
    idle_inputs(); drive_req(mk(1, 32'h10, 0, 2, 0, 0)); model_check(); tick();
    bus.data_gnt = 1; drive_req(mk(2, 32'h14, 0, 2, 0, 0)); model_check();
    chk("t4_ready2", bus.x_mem_ready, 1); tick();
    drive_req(mk(3, 32'h18, 0, 2, 0, 0)); model_check();
    chk("t4_ready3a", bus.x_mem_ready, 0); tick();
    bus.data_gnt = 0; model_check(); chk("t4_ready3b", bus.x_mem_ready, 0); tick();
    bus.data_rvalid = 1; bus.data_rdata = 32'h11; model_check();
    chk("t4_ready3c", bus.x_mem_ready, 1); chk("t4_id1", bus.x_mem_result_id, 1); tick();
    idle_inputs(); bus.data_gnt = 1; bus.data_rvalid = 1; bus.data_rdata = 32'h22; model_check();
    chk("t4_id2", bus.x_mem_result_id, 2); tick();
    idle_inputs(); bus.data_rvalid = 1; model_check(); chk("t4_id3", bus.x_mem_result_id, 3); tick();

    // Busy blocks acceptance but not the held grant; error flag passes through
    idle_inputs(); drive_req(mk(7, 32'h40, 0, 2, 0, 0)); model_check(); tick();
    bus.data_gnt = 1; lsu_busy = 1; drive_req(mk(8, 32'h44, 0, 2, 0, 0)); model_check();
    chk("t5_busy_ready", bus.x_mem_ready, 0); tick();
    bus.data_gnt = 0; lsu_busy = 0; bus.data_rvalid = 1; bus.data_err = 1; model_check();
    chk("t5_granted", bus.data_req, 0); chk("t5_err", bus.x_mem_result_err, 1); tick();
    idle_inputs(); bus.data_gnt = 1; model_check(); tick();
    bus.data_gnt = 0; bus.data_rvalid = 1; model_check(); chk("t5_id8", bus.x_mem_result_id, 8); tick();

    // Reset while REQ is held and one transaction is in flight
    idle_inputs(); drive_req(mk(9, 32'h80, 0, 2, 0, 0)); model_check(); tick();
    bus.data_gnt = 1; drive_req(mk(10, 32'h84, 0, 2, 0, 0)); model_check(); tick();
    idle_inputs(); rst = 1; #1;
    chk("t6_req", bus.data_req, 0); chk("t6_ready", bus.x_mem_ready, 0);
    pend_v = 0; inflight.delete();
    @(posedge clk); #1; rst = 0;
    bus.data_rvalid = 1; model_check(); chk("t6_noresult", bus.x_mem_result_valid, 0); tick();

    // Randomized traffic
    idle_inputs(); hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        if ($urandom % 3 != 0) begin drive_req(rand_req()); hold = 1; end
        else bus.x_mem_valid = 0;
      end
      lsu_busy = ($urandom % 5 == 0);
      bus.data_gnt = 1'($urandom);
      bus.data_rvalid = (inflight.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      bus.data_rdata = $urandom;
      bus.data_err = ($urandom % 6 == 0);
      model_check();
      if (m_hs) hold = 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
